// File: rtl/tw_rom3_loader_pkg.sv
// Shared definitions for the TW_ROM3 stage-0 twiddle loader:
// the ROM3_w write-type encodings, the loader state enum and the
// default sizes that the twiddle ROM also uses.
package tw_rom3_loader_pkg;

   localparam int DW_DEF      = 64;
   localparam int ENTRIES_DEF = 4;

   localparam logic [1:0] ROM3_W_NONE = 2'd0;
   localparam logic [1:0] ROM3_W_HI   = 2'd1;
   localparam logic [1:0] ROM3_W_LO   = 2'd2;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      COL_HI   = 4'd1,
      WAIT_HI  = 4'd2,
      BURST_HI = 4'd3,
      GAP      = 4'd4,
      COL_LO   = 4'd5,
      WAIT_LO  = 4'd6,
      BURST_LO = 4'd7,
      FIN      = 4'd8
   } state_t;

   // True in the states that take words from the input stream.
   function automatic logic is_col(input state_t s);
      return (s == COL_HI) || (s == COL_LO);
   endfunction

endpackage

// File: rtl/tw_rom3_loader_if.sv
// Stream, consumer-write and control signals of the twiddle loader.
// master = the side that feeds the loader, slave = the loader itself.
interface tw_rom3_loader_if
   import tw_rom3_loader_pkg::*;
#(
   parameter int DW = DW_DEF
);
   logic          load_start;
   logic          wr_allow;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [DW-1:0] horizontal_data_out;
   logic [1:0]    ROM3_w;
   logic          busy;
   logic          done;

   modport master (
      output load_start, wr_allow, in_valid, in_data,
      input  in_ready, horizontal_data_out, ROM3_w, busy, done
   );

   modport slave (
      input  load_start, wr_allow, in_valid, in_data,
      output in_ready, horizontal_data_out, ROM3_w, busy, done
   );
endinterface

// File: rtl/tw_rom3_loader_half_buf.sv
// One half-set buffer: ENTRIES x DW words with independent write and
// read indices and a full flag. Reused for the high and low halves.
// Storage is deliberately left unreset; only the bookkeeping resets.
module tw_half_buf
   import tw_rom3_loader_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int CW      = $clog2(ENTRIES)
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          wr_last,
   output logic          rd_last,
   output logic          full
);

   localparam logic [CW-1:0] IDX_ONE  = CW'(1);
   localparam logic [CW-1:0] IDX_LAST = CW'(ENTRIES - 1);

   logic [DW-1:0] mem_r [ENTRIES];
   logic [CW-1:0] wr_idx_r;
   logic [CW-1:0] rd_idx_r;
   logic          full_r;

   assign rd_data = mem_r[rd_idx_r];
   assign wr_last = (wr_idx_r == IDX_LAST);
   assign rd_last = (rd_idx_r == IDX_LAST);
   assign full    = full_r;

   // Indices wrap naturally at ENTRIES; full is set by the last write, cleared by the last read.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_r <= {CW{1'b0}};
         rd_idx_r <= {CW{1'b0}};
         full_r   <= 1'b0;
      end else if (clr) begin
         wr_idx_r <= {CW{1'b0}};
         rd_idx_r <= {CW{1'b0}};
         full_r   <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_idx_r <= wr_idx_r + IDX_ONE;
         end
         if (rd_en) begin
            rd_idx_r <= rd_idx_r + IDX_ONE;
         end
         if (wr_en && wr_last) begin
            full_r <= 1'b1;
         end else if (rd_en && rd_last) begin
            full_r <= 1'b0;
         end
      end
   end

   // Word storage, written on each accepted stream word.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_r[wr_idx_r] <= wr_data;
      end
   end

endmodule

// File: rtl/tw_rom3_loader.sv
// Upstream feeder for the radix-16 stage-0 twiddle buffer in TW_ROM3.
// Collects one half-set of ENTRIES words, waits for wr_allow, then
// replays it as an unbroken burst (ROM3_w=HI), inserts one idle cycle
// so the consumer's write index returns to 0, and repeats for the low
// halves (ROM3_w=LO). in_ready is the only combinational output.
module tw_rom3_loader
   import tw_rom3_loader_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int CW      = $clog2(ENTRIES)
) (
   input logic             CLK,
   input logic             rst_n,
   tw_rom3_loader_if.slave bus
);

   state_t        state_r;
   state_t        state_s;
   logic          in_ready_s;
   logic          hs_s;
   logic          clr_s;
   logic          burst_s;
   logic [1:0]    rom3_w_s;
   logic [DW-1:0] rd_data_s;
   logic          wr_last_s;
   logic          rd_last_s;
   logic          full_s;

   logic [1:0]    rom3_w_r;
   logic [DW-1:0] data_r;
   logic          busy_r;
   logic          done_r;

   assign in_ready_s = is_col(state_r);
   assign hs_s       = bus.in_valid && in_ready_s;
   assign clr_s      = (state_r == IDLE) && bus.load_start;

   assign bus.in_ready            = in_ready_s;
   assign bus.ROM3_w              = rom3_w_r;
   assign bus.horizontal_data_out = data_r;
   assign bus.busy                = busy_r;
   assign bus.done                = done_r;

   tw_half_buf #(
      .DW      (DW),
      .ENTRIES (ENTRIES),
      .CW      (CW)
   ) u_half_buf (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .clr     (clr_s),
      .wr_en   (hs_s),
      .wr_data (bus.in_data),
      .rd_en   (burst_s),
      .rd_data (rd_data_s),
      .wr_last (wr_last_s),
      .rd_last (rd_last_s),
      .full    (full_s)
   );

   // State register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic plus the burst read enable and write-type decode.
   always_comb begin
      state_s  = state_r;
      burst_s  = 1'b0;
      rom3_w_s = ROM3_W_NONE;
      case (state_r)
         IDLE: begin
            if (bus.load_start) state_s = COL_HI;
            else                state_s = IDLE;
         end
         COL_HI: begin
            if (hs_s && wr_last_s) state_s = WAIT_HI;
            else                   state_s = COL_HI;
         end
         WAIT_HI: begin
            // full_s guards against ever bursting a partial buffer.
            if (bus.wr_allow && full_s) state_s = BURST_HI;
            else                        state_s = WAIT_HI;
         end
         BURST_HI: begin
            burst_s  = 1'b1;
            rom3_w_s = ROM3_W_HI;
            if (rd_last_s) state_s = GAP;
            else           state_s = BURST_HI;
         end
         GAP: begin
            state_s = COL_LO;
         end
         COL_LO: begin
            if (hs_s && wr_last_s) state_s = WAIT_LO;
            else                   state_s = COL_LO;
         end
         WAIT_LO: begin
            if (bus.wr_allow && full_s) state_s = BURST_LO;
            else                        state_s = WAIT_LO;
         end
         BURST_LO: begin
            burst_s  = 1'b1;
            rom3_w_s = ROM3_W_LO;
            if (rd_last_s) state_s = FIN;
            else           state_s = BURST_LO;
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Registered outputs; data holds its last burst value between bursts.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         rom3_w_r <= ROM3_W_NONE;
         data_r   <= {DW{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         rom3_w_r <= rom3_w_s;
         busy_r   <= (state_s != IDLE);
         done_r   <= (state_r == FIN);
         if (burst_s) begin
            data_r <= rd_data_s;
         end
      end
   end

endmodule

// File: tb/tb_tw_rom3_loader.sv
// Self-checking bench for tw_rom3_loader: random words, bubbles,
// wr_allow stalls, spurious load_start and a mid-burst reset, checked
// against an expected word order and cycle-count arithmetic.
module tb_tw_rom3_loader;

   localparam int DW = 64;
   localparam int N  = 4;

   logic CLK   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] words [8];
   logic [DW-1:0] last_data;

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   tw_rom3_loader_if #(.DW(DW)) bus ();

   tw_rom3_loader #(.DW(DW), .ENTRIES(N), .CW(2)) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
      check_eq({tag, "_rom3_w"}, {62'd0, bus.ROM3_w}, 64'd0);
      check_eq({tag, "_data"}, bus.horizontal_data_out, 64'd0);
      check_eq({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
      check_eq({tag, "_done"}, {63'd0, bus.done}, 64'd0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < 8; k++) words[k] = {$urandom, $urandom};
   endtask

   task automatic fill_seq(input int base);
      for (int k = 0; k < 8; k++) words[k] = 64'(base + k);
   endtask

   task automatic idle(input int n);
      bus.load_start = 1'b0;
      repeat (n) begin
         @(negedge CLK);
         check_eq("idle_busy", {63'd0, bus.busy}, 64'd0);
         check_eq("idle_rom3_w", {62'd0, bus.ROM3_w}, 64'd0);
      end
   endtask

   // One load. Called and returns just after a negedge.
   // bmode: 0 no bubbles, 1 three bubbles before word index 2, 2 random bubbles.
   task automatic run_load(input int bmode, input int w_hi, input int w_lo,
                           input bit spur, input bit do_rst);
      int L, D, i, bub, hold, run, got, burst_exp;
      bit hs, in_wait, bubble;
      check_eq("start_in_ready", {63'd0, bus.in_ready}, 64'd0);
      bus.load_start = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_data    = words[0];
      bus.wr_allow   = 1'b1;
      L = cyc + 1;
      i = 0; bub = 0; hold = 0; run = 0; got = 0; burst_exp = -1;
      hs = 1'b0; in_wait = 1'b0;
      while (1) begin
         @(posedge CLK); #1;
         D = L + 20 + bub + w_hi + w_lo;
         if (do_rst && cyc == D - 4) begin
            rst_n = 1'b0;
            #1;
            check_outputs_zero("rst_mid_burst");
            last_data      = '0;
            bus.load_start = 1'b0;
            @(negedge CLK);
            rst_n = 1'b1;
            return;
         end
         bus.load_start = spur && (cyc < D) && ($urandom_range(0, 3) == 0);
         if (hs && i < 8) begin
            i++;
            if (i == 4) hold = w_hi + 1;
            if (i == 8) hold = w_lo + 1;
         end
         in_wait = 1'b0;
         if (hold > 0) begin
            bus.wr_allow = (hold == 1);
            if (hold == 1) burst_exp = cyc + 2;
            hold--;
            in_wait = 1'b1;
         end else begin
            bus.wr_allow = 1'($urandom_range(0, 1));
         end
         if (i < 8) begin
            bubble = 1'b0;
            if (i % 4 != 0) begin
               if (bmode == 1 && i == 2 && bub < 3) bubble = 1'b1;
               if (bmode == 2 && $urandom_range(0, 3) == 0) bubble = 1'b1;
            end
            if (bubble) begin
               bus.in_valid = 1'b0;
               bus.in_data  = {$urandom, $urandom};
               bub++;
            end else begin
               bus.in_valid = 1'b1;
               bus.in_data  = words[i];
            end
         end else begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = {$urandom, $urandom};
         end

         @(negedge CLK);
         D = L + 20 + bub + w_hi + w_lo;
         check_eq("busy", {63'd0, bus.busy}, {63'd0, (cyc >= L) && (cyc < D)});
         check_eq("done", {63'd0, bus.done}, {63'd0, cyc == D});
         check_eq("rom3_w_legal", {63'd0, bus.ROM3_w == 2'd3}, 64'd0);
         if (in_wait) begin
            check_eq("wait_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check_eq("wait_rom3_w", {62'd0, bus.ROM3_w}, 64'd0);
         end
         if (i < 8 && !bus.in_valid) begin
            check_eq("bubble_in_ready", {63'd0, bus.in_ready}, 64'd1);
         end
         if (bus.ROM3_w != 2'd0) begin
            if (run == 0) check_eq("burst_start", 64'(cyc), 64'(burst_exp));
            run++;
            if (got < 8) begin
               check_eq("rom3_w", {62'd0, bus.ROM3_w}, (got < 4) ? 64'd1 : 64'd2);
               check_eq("burst_data", bus.horizontal_data_out, words[got]);
               last_data = words[got];
               got++;
            end else begin
               check_eq("extra_burst_word", {62'd0, bus.ROM3_w}, 64'd0);
            end
         end else begin
            if (run != 0) begin
               check_eq("burst_len", 64'(run), 64'(N));
               run = 0;
            end
            check_eq("hold_data", bus.horizontal_data_out, last_data);
         end
         hs = bus.in_valid && bus.in_ready;
         if (hs && i >= 8) check_eq("late_accept", {63'd0, bus.in_ready}, 64'd0);
         if (cyc == D) break;
      end
      bus.load_start = 1'b0;
      check_eq("words_out", 64'(got), 64'd8);
   endtask

   initial begin
      bus.load_start = 1'b0;
      bus.wr_allow   = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      last_data      = '0;
      repeat (3) @(negedge CLK);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Nominal: words 1..8, done at L+20.
      fill_seq(1);
      run_load(0, 0, 0, 1'b0, 1'b0);
      idle(2);

      // Three-cycle bubble between words 2 and 3.
      fill_random();
      run_load(1, 0, 0, 1'b0, 1'b0);
      idle(1);

      // wr_allow low for 10 cycles after the 4th high word.
      fill_random();
      run_load(0, 10, $urandom_range(0, 5), 1'b0, 1'b0);
      idle(1);

      // Spurious load_start pulses while busy.
      fill_random();
      run_load(0, 0, 0, 1'b1, 1'b0);
      idle(1);

      // Reset in the second BURST_LO cycle, then a clean load of 0xA..0x11.
      fill_random();
      run_load(2, 2, 0, 1'b1, 1'b1);
      idle(2);
      fill_seq(32'hA);
      run_load(0, 0, 0, 1'b0, 1'b0);

      // Back-to-back random loads, load_start on the cycle after done.
      for (int k = 0; k < 6; k++) begin
         fill_random();
         run_load(2, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tw_rom3_loader.md
Name: tw_rom3_loader

Overview:
Upstream feeder for the radix-16 stage-0 twiddle buffer in the TW_ROM3 block. It accepts 64-bit twiddle halves from a valid/ready stream, buffers one half-set of ENTRIES words, then replays each set as an unbroken burst on horizontal_data_out with ROM3_w=1 (high halves) or ROM3_w=2 (low halves). This matches the consumer's write-index counter, which advances on every cycle ROM3_w is nonzero and clears to 0 whenever ROM3_w=0.

Parameters:
DW, 64, width of one twiddle half word
ENTRIES, 4, words per burst; power of two, at least 2; equals the consumer's init_store_data
CW, 2, index counter width, log2(ENTRIES)

Ports:
CLK  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE
wr_allow  input  1  consumer may be written (high while the stage-0 twiddle buffer is not being read)
in_valid  input  1  in_data is valid
in_data  input  DW  twiddle half word; words 0..ENTRIES-1 are high halves, the next ENTRIES words are low halves
in_ready  output  1  loader accepts in_data this cycle
horizontal_data_out  output  DW  data to the consumer's horizontal_data_in
ROM3_w  output  2  0 = no write, 1 = high-half write, 2 = low-half write; 3 is never driven
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the load completes

Behaviour:
- Reset (asynchronous, any state, including mid-burst): state goes to IDLE, idx=0; in_ready=0, ROM3_w=0, horizontal_data_out=0, busy=0, done=0. The buffer array is not reset.
- All outputs are registered except in_ready, which decodes combinationally from state.
- A handshake is in_valid && in_ready. The accepted word is written to buf[idx], then idx increments, wrapping at ENTRIES-1.
- States:
  - IDLE: in_ready=0. load_start moves to COL_HI with idx=0.
  - COL_HI: in_ready=1. On the handshake at idx=ENTRIES-1, move to WAIT_HI.
  - WAIT_HI: in_ready=0. Stay while wr_allow=0. When wr_allow=1, move to BURST_HI with idx=0.
  - BURST_HI: ENTRIES cycles. Each cycle drives ROM3_w=1 and horizontal_data_out=buf[idx]; idx++. After the last word, move to GAP.
  - GAP: one cycle with ROM3_w=0 so the consumer's counter returns to 0. Move to COL_LO.
  - COL_LO, WAIT_LO, BURST_LO: same as the high-half states, with ROM3_w=2.
  - FIN: done=1 for one cycle, then IDLE.
- Burst timing: the first burst word appears on the cycle after the WAIT-to-BURST transition edge. ROM3_w is nonzero for exactly ENTRIES consecutive cycles. After the burst, ROM3_w=0 and horizontal_data_out holds its last value.
- wr_allow is sampled only in WAIT states. Deasserting it during a burst does not stall or split the burst.
- A gap in in_valid during COL states just waits. idx and the buffer hold their values.
- load_start while busy=1 is ignored.
- in_data is never accepted outside COL states.
- A burst never starts with a partial buffer.
- Minimum load latency, with in_valid and wr_allow held high: ENTRIES+1 collect/wait cycles plus ENTRIES burst cycles per half, plus GAP and FIN. For ENTRIES=4 this is 2*(4+1+4)+1+1 = 20 cycles from load_start to done.

Decomposition:
- Shared package holds:
  - The ROM3_w encodings: ROM3_W_NONE=0, ROM3_W_HI=1, ROM3_W_LO=2.
  - The state enum.
  - DW and ENTRIES defaults, shared with the twiddle ROM.
- One natural sub-module, tw_half_buf: the ENTRIES x DW register array with write index, read index and full flag, instantiated once and reused for both halves.

Test Plan:
- Nominal load: load_start, then in_data=1..8 with in_valid held high and wr_allow=1. Required: ROM3_w=1 with data 1,2,3,4 on consecutive cycles; then one ROM3_w=0 cycle; then ROM3_w=2 with data 5,6,7,8; done pulses once at cycle 20 after load_start. With the TW_ROM3 model attached, entry[k] = {k+1, k+5}.
- Stream bubbles: in_valid low for 3 cycles between words 2 and 3. Required: in_ready stays 1 through the bubble, buffer contents are unchanged, and the burst is still 4 contiguous cycles with no ROM3_w=0 gap inside it.
- wr_allow held at 0 for 10 cycles after the 4th high word. Required: the loader stays in WAIT_HI, in_ready=0, ROM3_w=0; the burst starts the cycle after wr_allow rises. Dropping wr_allow mid-burst has no effect on the burst.
- load_start pulsed during COL_LO and during BURST_HI. Required: no restart; the sequence and done timing match the nominal case.
- rst_n asserted in the second cycle of BURST_LO. Required: outputs are 0 and busy=0 immediately. A following load with data 0xA..0x11 completes normally and the earlier load's data never appears.
- Back-to-back loads, with load_start on the cycle after done. Required: the second sequence starts in COL_HI, the index starts at 0, and ROM3_w is never 3.
